branch_resolve_ctrl: RTL and testbench
======================================

// Module: branch_resolve_ctrl
// PURPOSE
//  Sequencer for the branch comparator in the multicycle core. It accepts one conditional
//  branch from decode and drives the comparator with latched rs1/rs2 and the unsigned select.
//  It then turns less/equal into a taken decision, next PC, misprediction and exception flags.
//  It holds the result until the fetch/redirect stage accepts it, and keeps saturating
//  branch and mispredict counters.
// PARAMETERS
//  XLEN   32  data/PC width
//  CNT_W  16  width of each statistics counter
// PORTS
//  clk_i            in   1      clock, rising edge
//  rst_i            in   1      async reset, active-high
//  flush_i          in   1      sync pipeline flush, highest priority
//  req_valid_i      in   1      branch request valid
//  req_ready_o      out  1      unit can accept request
//  req_funct3_i     in   3      branch funct3
//  req_pc_i         in   XLEN   PC of branch
//  req_imm_i        in   XLEN   sign-extended B-imm
//  req_rs1_i        in   XLEN   rs1 value
//  req_rs2_i        in   XLEN   rs2 value
//  req_pred_taken_i in   1      front-end prediction
//  cmp_rs1_o        out  XLEN   to comparator rs1_data_i
//  cmp_rs2_o        out  XLEN   to comparator rs2_data_i
//  cmp_unsigned_o   out  1      to comparator br_unsigned_i
//  cmp_less_i       in   1      from comparator br_less_o (combinational)
//  cmp_equal_i      in   1      from comparator br_equal_o (combinational)
//  res_valid_o      out  1      result valid
//  res_ready_i      in   1      consumer accepts result
//  res_taken_o      out  1      branch taken
//  res_target_o     out  XLEN   next PC (taken: pc+imm, else pc+4)
//  res_mispred_o    out  1      taken != predicted (legal only)
//  res_illegal_o    out  1      funct3 is 010 or 011
//  res_misalign_o   out  1      taken && target[1:0] != 0
//  cnt_branch_o     out  CNT_W  legal branches retired
//  cnt_mispred_o    out  CNT_W  mispredicted branches retired
// BEHAVIOUR
//  Reset: state=IDLE; every registered output (cmp_*, res_*, cnt_*) = 0.
//   req_ready_o = (state==IDLE) && !flush_i. It is combinational, so it is 1 after reset.
//  FSM IDLE->CMP->RESP->IDLE:
//   IDLE: on req_valid_i && req_ready_o, latch funct3/pc/imm/pred.
//    Load cmp_rs1_o/cmp_rs2_o from rs1/rs2.
//    Load cmp_unsigned_o = funct3[1]. Go to CMP.
//   CMP: one cycle. Sample cmp_less_i/cmp_equal_i.
//    Register the res_* fields. res_valid_o=1 next cycle. Go to RESP.
//   RESP: hold all res_* stable while res_valid_o && !res_ready_i.
//    On handshake: res_valid_o=0, update counters, go to IDLE.
//    A new request is not accepted until the next cycle.
//  Latency: accept in cycle N gives res_valid_o in N+2. Throughput is 1 branch per 3 cycles
//   with res_ready_i tied high.
//  Taken by funct3: 000 eq; 001 !eq; 100/110 less; 101/111 !less.
//   For 010/011: taken=0, illegal=1, mispred=0, misalign=0.
//  Target: pc+imm mod 2^XLEN if taken, else pc+4 mod 2^XLEN. Wrap-around is silent.
//  Counters increment only on a result handshake:
//   cnt_branch_o when !illegal; cnt_mispred_o when mispred.
//   Both saturate at all-ones and never wrap.
//  flush_i in any state: go to IDLE next cycle and set res_valid_o=0.
//   The in-flight result is dropped and the counters do not change.
//   A flush in the same cycle as res_ready_i drops the result and does not count it.
//   cmp_* keep their value.
//  rst_i mid-operation: immediate return to reset state; the partial result is discarded.
//  cmp_* change only on request acceptance, so comparator inputs are stable in CMP.
// TESTING
//  BEQ rs1=rs2=5, pc=0x100, imm=0x20, pred=0 -> N+2: taken=1, target=0x120, mispred=1;
//   cnt_mispred=1.
//  BLT rs1=0xFFFFFFFF, rs2=1 -> taken=1 (signed); BLTU same operands -> taken=0,
//   target=pc+4, cmp_unsigned_o=1.
//  BGE pc=0xFFFFFFFC, imm=8, rs1=rs2 -> taken, target=0x00000004 (wrap);
//   imm=2 -> misalign=1.
//  funct3=010 -> illegal=1, taken=0; cnt_branch_o unchanged.
//  res_ready_i low 4 cycles -> res_* stable, req_ready_o=0 throughout;
//   flush_i in CMP -> no result, counters unchanged.
//  Preload counters to 0xFFFF and retire a mispredicted BNE -> both stay 0xFFFF;
//   rst_i asserted in RESP -> all outputs 0 immediately.

Source files
------------

// File: rtl/branch_resolve_ctrl_if.sv
// Handshake and comparator bundle for the branch resolve sequencer.
// slave = sequencer view, master = decode/fetch/comparator view.
interface branch_resolve_ctrl_if #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
);
    logic             flush_i;
    logic             req_valid_i;
    logic             req_ready_o;
    logic [2:0]       req_funct3_i;
    logic [XLEN-1:0]  req_pc_i;
    logic [XLEN-1:0]  req_imm_i;
    logic [XLEN-1:0]  req_rs1_i;
    logic [XLEN-1:0]  req_rs2_i;
    logic             req_pred_taken_i;
    logic [XLEN-1:0]  cmp_rs1_o;
    logic [XLEN-1:0]  cmp_rs2_o;
    logic             cmp_unsigned_o;
    logic             cmp_less_i;
    logic             cmp_equal_i;
    logic             res_valid_o;
    logic             res_ready_i;
    logic             res_taken_o;
    logic [XLEN-1:0]  res_target_o;
    logic             res_mispred_o;
    logic             res_illegal_o;
    logic             res_misalign_o;
    logic [CNT_W-1:0] cnt_branch_o;
    logic [CNT_W-1:0] cnt_mispred_o;

    modport slave (
        input  flush_i, req_valid_i, req_funct3_i, req_pc_i, req_imm_i,
        input  req_rs1_i, req_rs2_i, req_pred_taken_i,
        input  cmp_less_i, cmp_equal_i, res_ready_i,
        output req_ready_o, cmp_rs1_o, cmp_rs2_o, cmp_unsigned_o,
        output res_valid_o, res_taken_o, res_target_o, res_mispred_o,
        output res_illegal_o, res_misalign_o, cnt_branch_o, cnt_mispred_o
    );

    modport master (
        output flush_i, req_valid_i, req_funct3_i, req_pc_i, req_imm_i,
        output req_rs1_i, req_rs2_i, req_pred_taken_i,
        output cmp_less_i, cmp_equal_i, res_ready_i,
        input  req_ready_o, cmp_rs1_o, cmp_rs2_o, cmp_unsigned_o,
        input  res_valid_o, res_taken_o, res_target_o, res_mispred_o,
        input  res_illegal_o, res_misalign_o, cnt_branch_o, cnt_mispred_o
    );
endinterface

// File: rtl/branch_resolve_ctrl.sv
// Branch resolve sequencer: IDLE -> CMP -> RESP, drives the external
// comparator, registers the decision and keeps saturating counters.
module branch_resolve_ctrl #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    branch_resolve_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CMP, RESP} state_e;

    state_e           state_q, state_d;
    logic [2:0]       funct3_q, funct3_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    logic             pred_q, pred_d;
    logic [XLEN-1:0]  rs1_q, rs1_d;
    logic [XLEN-1:0]  rs2_q, rs2_d;
    logic             uns_q, uns_d;
    logic             vld_q, vld_d;
    logic             tkn_q, tkn_d;
    logic [XLEN-1:0]  tgt_q, tgt_d;
    logic             mis_q, mis_d;
    logic             ill_q, ill_d;
    logic             mal_q, mal_d;
    logic [CNT_W-1:0] cbr_q, cbr_d;
    logic [CNT_W-1:0] cmp_q, cmp_d;

    logic            taken_c, illegal_c, mispred_c, misalign_c;
    logic [XLEN-1:0] target_c;
    logic            ready_c;

    assign ready_c = (state_q == IDLE) && !bus.flush_i;

    always_comb begin
        taken_c   = 1'b0;
        illegal_c = 1'b0;
        unique case (funct3_q)
            3'b000:         taken_c = bus.cmp_equal_i;
            3'b001:         taken_c = !bus.cmp_equal_i;
            3'b100, 3'b110: taken_c = bus.cmp_less_i;
            3'b101, 3'b111: taken_c = !bus.cmp_less_i;
            default:        illegal_c = 1'b1;
        endcase
        target_c   = taken_c ? (pc_q + imm_q) : (pc_q + XLEN'(4));
        mispred_c  = !illegal_c && (taken_c != pred_q);
        misalign_c = taken_c && (target_c[1:0] != 2'b00);
    end

    always_comb begin
        state_d  = state_q;
        funct3_d = funct3_q;
        pc_d     = pc_q;
        imm_d    = imm_q;
        pred_d   = pred_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        uns_d    = uns_q;
        vld_d    = vld_q;
        tkn_d    = tkn_q;
        tgt_d    = tgt_q;
        mis_d    = mis_q;
        ill_d    = ill_q;
        mal_d    = mal_q;
        cbr_d    = cbr_q;
        cmp_d    = cmp_q;
        if (bus.flush_i) begin
            state_d = IDLE;
            vld_d   = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: if (bus.req_valid_i) begin
                    funct3_d = bus.req_funct3_i;
                    pc_d     = bus.req_pc_i;
                    imm_d    = bus.req_imm_i;
                    pred_d   = bus.req_pred_taken_i;
                    rs1_d    = bus.req_rs1_i;
                    rs2_d    = bus.req_rs2_i;
                    uns_d    = bus.req_funct3_i[1];
                    state_d  = CMP;
                end
                CMP: begin
                    tkn_d   = taken_c;
                    tgt_d   = target_c;
                    mis_d   = mispred_c;
                    ill_d   = illegal_c;
                    mal_d   = misalign_c;
                    vld_d   = 1'b1;
                    state_d = RESP;
                end
                RESP: if (bus.res_ready_i) begin
                    vld_d   = 1'b0;
                    state_d = IDLE;
                    // saturate rather than wrap
                    if (!ill_q && cbr_q != '1) cbr_d = cbr_q + CNT_W'(1);
                    if (mis_q && cmp_q != '1)  cmp_d = cmp_q + CNT_W'(1);
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            funct3_q <= '0;
            pc_q     <= '0;
            imm_q    <= '0;
            pred_q   <= 1'b0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            uns_q    <= 1'b0;
            vld_q    <= 1'b0;
            tkn_q    <= 1'b0;
            tgt_q    <= '0;
            mis_q    <= 1'b0;
            ill_q    <= 1'b0;
            mal_q    <= 1'b0;
            cbr_q    <= '0;
            cmp_q    <= '0;
        end else begin
            state_q  <= state_d;
            funct3_q <= funct3_d;
            pc_q     <= pc_d;
            imm_q    <= imm_d;
            pred_q   <= pred_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            uns_q    <= uns_d;
            vld_q    <= vld_d;
            tkn_q    <= tkn_d;
            tgt_q    <= tgt_d;
            mis_q    <= mis_d;
            ill_q    <= ill_d;
            mal_q    <= mal_d;
            cbr_q    <= cbr_d;
            cmp_q    <= cmp_d;
        end
    end

    assign bus.req_ready_o    = ready_c;
    assign bus.cmp_rs1_o      = rs1_q;
    assign bus.cmp_rs2_o      = rs2_q;
    assign bus.cmp_unsigned_o = uns_q;
    assign bus.res_valid_o    = vld_q;
    assign bus.res_taken_o    = tkn_q;
    assign bus.res_target_o   = tgt_q;
    assign bus.res_mispred_o  = mis_q;
    assign bus.res_illegal_o  = ill_q;
    assign bus.res_misalign_o = mal_q;
    assign bus.cnt_branch_o   = cbr_q;
    assign bus.cnt_mispred_o  = cmp_q;
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Directed bench for branch_resolve_ctrl; a second narrow-counter
// instance exercises counter saturation.
module tb_branch_resolve_ctrl;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_fail;

    branch_resolve_ctrl_if #(.XLEN(32), .CNT_W(16)) bus ();
    branch_resolve_ctrl_if #(.XLEN(32), .CNT_W(2))  bus2 ();

    branch_resolve_ctrl #(.XLEN(32), .CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus));
    branch_resolve_ctrl #(.XLEN(32), .CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .bus(bus2));

    // comparator models
    assign bus.cmp_equal_i = (bus.cmp_rs1_o == bus.cmp_rs2_o);
    assign bus.cmp_less_i  = bus.cmp_unsigned_o ?
        (bus.cmp_rs1_o < bus.cmp_rs2_o) :
        ($signed(bus.cmp_rs1_o) < $signed(bus.cmp_rs2_o));
    assign bus2.cmp_equal_i = (bus2.cmp_rs1_o == bus2.cmp_rs2_o);
    assign bus2.cmp_less_i  = bus2.cmp_unsigned_o ?
        (bus2.cmp_rs1_o < bus2.cmp_rs2_o) :
        ($signed(bus2.cmp_rs1_o) < $signed(bus2.cmp_rs2_o));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {taken, target, mispred, illegal, misalign}
    function automatic logic [35:0] res_vec();
        return {bus.res_taken_o, bus.res_target_o, bus.res_mispred_o,
                bus.res_illegal_o, bus.res_misalign_o};
    endfunction

    task automatic send(input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [31:0] a,
                        input logic [31:0] b, input logic pred);
        @(negedge clk);
        bus.req_valid_i      = 1'b1;
        bus.req_funct3_i     = f3;
        bus.req_pc_i         = pc;
        bus.req_imm_i        = imm;
        bus.req_rs1_i        = a;
        bus.req_rs2_i        = b;
        bus.req_pred_taken_i = pred;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        @(negedge clk);
    endtask

    task automatic ack();
        bus.res_ready_i = 1'b1;
        @(negedge clk);
        bus.res_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.req_ready_o !== 1'b1 || bus.res_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hs: ready=%b valid=%b want 1 0",
                     bus.req_ready_o, bus.res_valid_o);
        end
        n_chk++;
        if ({bus.cnt_branch_o, bus.cnt_mispred_o, bus.cmp_rs1_o,
             bus.cmp_unsigned_o, res_vec()} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: cnt=%h/%h rs1=%h res=%h want 0",
                     bus.cnt_branch_o, bus.cnt_mispred_o, bus.cmp_rs1_o,
                     res_vec());
        end
    endtask

    task automatic test_beq();
        @(negedge clk);
        bus.req_valid_i      = 1'b1;
        bus.req_funct3_i     = 3'b000;
        bus.req_pc_i         = 32'h100;
        bus.req_imm_i        = 32'h20;
        bus.req_rs1_i        = 32'd5;
        bus.req_rs2_i        = 32'd5;
        bus.req_pred_taken_i = 1'b0;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        n_chk++;
        if (bus.res_valid_o !== 1'b0 || bus.req_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL beq_n1: valid=%b ready=%b want 0 0",
                     bus.res_valid_o, bus.req_ready_o);
        end
        @(negedge clk);
        n_chk++;
        if (bus.res_valid_o !== 1'b1 ||
            res_vec() !== {1'b1, 32'h120, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL beq_res: valid=%b res=%h want 1 %h",
                     bus.res_valid_o, res_vec(),
                     {1'b1, 32'h120, 1'b1, 1'b0, 1'b0});
        end
        ack();
        n_chk++;
        if (bus.res_valid_o !== 1'b0 || bus.cnt_branch_o !== 16'd1 ||
            bus.cnt_mispred_o !== 16'd1) begin
            n_fail++;
            $display("FAIL beq_cnt: valid=%b cnt=%0d/%0d want 0 1/1",
                     bus.res_valid_o, bus.cnt_branch_o, bus.cnt_mispred_o);
        end
    endtask

    task automatic test_blt_bltu();
        send(3'b100, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1);
        n_chk++;
        if (res_vec() !== {1'b1, 32'h240, 1'b0, 1'b0, 1'b0} ||
            bus.cmp_unsigned_o !== 1'b0) begin
            n_fail++;
            $display("FAIL blt: res=%h uns=%b want %h 0", res_vec(),
                     bus.cmp_unsigned_o, {1'b1, 32'h240, 3'b000});
        end
        ack();
        send(3'b110, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 1'b1);
        n_chk++;
        if (res_vec() !== {1'b0, 32'h204, 1'b1, 1'b0, 1'b0} ||
            bus.cmp_unsigned_o !== 1'b1) begin
            n_fail++;
            $display("FAIL bltu: res=%h uns=%b want %h 1", res_vec(),
                     bus.cmp_unsigned_o, {1'b0, 32'h204, 3'b100});
        end
        ack();
        n_chk++;
        if (bus.cnt_branch_o !== 16'd3 || bus.cnt_mispred_o !== 16'd2) begin
            n_fail++;
            $display("FAIL blt_cnt: cnt=%0d/%0d want 3/2",
                     bus.cnt_branch_o, bus.cnt_mispred_o);
        end
    endtask

    task automatic test_bge_wrap();
        send(3'b101, 32'hFFFF_FFFC, 32'd8, 32'd7, 32'd7, 1'b1);
        n_chk++;
        if (res_vec() !== {1'b1, 32'h0000_0004, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL bge_wrap: res=%h want %h", res_vec(),
                     {1'b1, 32'h4, 3'b000});
        end
        ack();
        send(3'b101, 32'hFFFF_FFFC, 32'd2, 32'd7, 32'd7, 1'b1);
        n_chk++;
        if (res_vec() !== {1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL bge_misalign: res=%h want %h", res_vec(),
                     {1'b1, 32'hFFFF_FFFE, 3'b001});
        end
        ack();
    endtask

    task automatic test_illegal();
        send(3'b010, 32'h300, 32'h80, 32'd1, 32'd1, 1'b1);
        n_chk++;
        if (res_vec() !== {1'b0, 32'h304, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL illegal_res: res=%h want %h", res_vec(),
                     {1'b0, 32'h304, 3'b010});
        end
        ack();
        n_chk++;
        if (bus.cnt_branch_o !== 16'd5 || bus.cnt_mispred_o !== 16'd2) begin
            n_fail++;
            $display("FAIL illegal_cnt: cnt=%0d/%0d want 5/2",
                     bus.cnt_branch_o, bus.cnt_mispred_o);
        end
    endtask

    task automatic test_backpressure();
        send(3'b001, 32'h400, 32'h10, 32'd1, 32'd2, 1'b1);
        bus.req_valid_i = 1'b1;
        bus.req_rs1_i   = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_chk++;
            if (bus.res_valid_o !== 1'b1 || bus.req_ready_o !== 1'b0 ||
                res_vec() !== {1'b1, 32'h410, 1'b0, 1'b0, 1'b0} ||
                bus.cmp_rs1_o !== 32'd1) begin
                n_fail++;
                $display("FAIL stall_%0d: v=%b rdy=%b res=%h rs1=%h want 1 0 %h 1",
                         i, bus.res_valid_o, bus.req_ready_o, res_vec(),
                         bus.cmp_rs1_o, {1'b1, 32'h410, 3'b000});
            end
        end
        bus.req_valid_i = 1'b0;
        ack();
        n_chk++;
        if (bus.cnt_branch_o !== 16'd6 || bus.cnt_mispred_o !== 16'd2 ||
            bus.res_valid_o !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_cnt: cnt=%0d/%0d v=%b want 6/2 0",
                     bus.cnt_branch_o, bus.cnt_mispred_o, bus.res_valid_o);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        bus.req_valid_i      = 1'b1;
        bus.req_funct3_i     = 3'b000;
        bus.req_pc_i         = 32'h600;
        bus.req_rs1_i        = 32'd9;
        bus.req_rs2_i        = 32'd9;
        bus.req_pred_taken_i = 1'b0;
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.flush_i     = 1'b1;
        #1;
        n_chk++;
        if (bus.req_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_rdy: ready=%b want 0", bus.req_ready_o);
        end
        @(negedge clk);
        bus.flush_i = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if (bus.res_valid_o !== 1'b0 || bus.req_ready_o !== 1'b1 ||
            bus.cnt_branch_o !== 16'd6 || bus.cnt_mispred_o !== 16'd2 ||
            bus.cmp_rs1_o !== 32'd9) begin
            n_fail++;
            $display("FAIL flush_cmp: v=%b rdy=%b cnt=%0d/%0d rs1=%h want 0 1 6/2 9",
                     bus.res_valid_o, bus.req_ready_o, bus.cnt_branch_o,
                     bus.cnt_mispred_o, bus.cmp_rs1_o);
        end
        send(3'b000, 32'h600, 32'h8, 32'd9, 32'd9, 1'b0);
        bus.flush_i     = 1'b1;
        bus.res_ready_i = 1'b1;
        @(negedge clk);
        bus.flush_i     = 1'b0;
        bus.res_ready_i = 1'b0;
        n_chk++;
        if (bus.res_valid_o !== 1'b0 || bus.cnt_branch_o !== 16'd6 ||
            bus.cnt_mispred_o !== 16'd2) begin
            n_fail++;
            $display("FAIL flush_resp: v=%b cnt=%0d/%0d want 0 6/2",
                     bus.res_valid_o, bus.cnt_branch_o, bus.cnt_mispred_o);
        end
    endtask

    task automatic test_back_to_back();
        int vcount;
        vcount = 0;
        @(negedge clk);
        bus.res_ready_i      = 1'b1;
        bus.req_valid_i      = 1'b1;
        bus.req_funct3_i     = 3'b000;
        bus.req_pc_i         = 32'h500;
        bus.req_imm_i        = 32'h4;
        bus.req_rs1_i        = 32'd3;
        bus.req_rs2_i        = 32'd3;
        bus.req_pred_taken_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (bus.res_valid_o === 1'b1) vcount++;
        end
        bus.req_valid_i = 1'b0;
        bus.res_ready_i = 1'b0;
        n_chk++;
        if (vcount !== 3 || bus.cnt_branch_o !== 16'd9 ||
            bus.cnt_mispred_o !== 16'd2) begin
            n_fail++;
            $display("FAIL b2b: results=%0d cnt=%0d/%0d want 3 9/2",
                     vcount, bus.cnt_branch_o, bus.cnt_mispred_o);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_saturate();
        logic [1:0] exp;
        bus2.res_ready_i      = 1'b1;
        bus2.req_funct3_i     = 3'b001;
        bus2.req_pc_i         = 32'h700;
        bus2.req_imm_i        = 32'h10;
        bus2.req_rs1_i        = 32'd1;
        bus2.req_rs2_i        = 32'd2;
        bus2.req_pred_taken_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus2.req_valid_i = 1'b1;
            @(negedge clk);
            bus2.req_valid_i = 1'b0;
            repeat (2) @(negedge clk);
            exp = (i >= 2) ? 2'd3 : 2'(i + 1);
            n_chk++;
            if (bus2.cnt_branch_o !== exp || bus2.cnt_mispred_o !== exp) begin
                n_fail++;
                $display("FAIL sat_%0d: cnt=%0d/%0d want %0d/%0d", i,
                         bus2.cnt_branch_o, bus2.cnt_mispred_o, exp, exp);
            end
        end
        bus2.res_ready_i = 1'b0;
    endtask

    task automatic test_rst_mid();
        send(3'b001, 32'h800, 32'h20, 32'd4, 32'd5, 1'b0);
        n_chk++;
        if (bus.res_valid_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_pre: valid=%b want 1", bus.res_valid_o);
        end
        rst = 1'b1;
        #1;
        n_chk++;
        if ({bus.res_valid_o, res_vec(), bus.cmp_rs1_o, bus.cmp_rs2_o,
             bus.cmp_unsigned_o, bus.cnt_branch_o, bus.cnt_mispred_o} !== '0 ||
            bus.req_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid: v=%b res=%h rs1=%h cnt=%0d/%0d rdy=%b want 0s rdy 1",
                     bus.res_valid_o, res_vec(), bus.cmp_rs1_o,
                     bus.cnt_branch_o, bus.cnt_mispred_o, bus.req_ready_o);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b1;
        bus.flush_i = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.req_funct3_i = 3'b000;
        bus.req_pc_i = '0;
        bus.req_imm_i = '0;
        bus.req_rs1_i = '0;
        bus.req_rs2_i = '0;
        bus.req_pred_taken_i = 1'b0;
        bus.res_ready_i = 1'b0;
        bus2.flush_i = 1'b0;
        bus2.req_valid_i = 1'b0;
        bus2.req_funct3_i = 3'b000;
        bus2.req_pc_i = '0;
        bus2.req_imm_i = '0;
        bus2.req_rs1_i = '0;
        bus2.req_rs2_i = '0;
        bus2.req_pred_taken_i = 1'b0;
        bus2.res_ready_i = 1'b0;
        test_reset();
        test_beq();
        test_blt_bltu();
        test_bge_wrap();
        test_illegal();
        test_backpressure();
        test_flush();
        test_back_to_back();
        test_saturate();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
